// File: rtl/word_aligner_pkg.sv
// Shared constants and types for the word aligner: K28.5 code groups, FSM state type, comma test.
// Optional feature macro used by the top: WORD_ALIGNER_REALIGN_CNT_EN.
package word_aligner_pkg;

   localparam int unsigned SYM_W    = 10;
   localparam logic [9:0]  K285_RDN = 10'h17C;
   localparam logic [9:0]  K285_RDP = 10'h283;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_CHECK    = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   function automatic logic is_k285(input logic [SYM_W-1:0] sym);
      return (sym == K285_RDN) || (sym == K285_RDP);
   endfunction

endpackage

// File: rtl/word_aligner_comma_finder.sv
// Combinational K28.5 search over the ten bit offsets of the 20-bit receive window.
// The window's top bit can never start a candidate, so it is not an input.
module comma_finder
   import word_aligner_pkg::*;
(
   input  logic [2*SYM_W-2:0] window_i,
   output logic               hit_o,
   output logic [3:0]         offset_o
);

   // Scan upward and keep the first hit so the lowest offset wins.
   always_comb begin
      hit_o    = 1'b0;
      offset_o = '0;
      for (int unsigned k = 0; k < SYM_W; k++) begin
         if (!hit_o && is_k285(window_i[k +: SYM_W])) begin
            hit_o    = 1'b1;
            offset_o = 4'(k);
         end
      end
   end

endmodule

// File: rtl/word_aligner.sv
// Comma-based 10b word aligner: acquires/loses lock on K28.5 at a consistent bit offset.
// Define WORD_ALIGNER_REALIGN_CNT_EN to add the Realign_Cnt output (lock-loss counter).
module word_aligner
   import word_aligner_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SYM_W,
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic                  Bit_Rate_Clk_10,
   input  logic                  Rst,
   input  logic [DATA_WIDTH-1:0] Data_in,
   input  logic                  Data_Valid,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  Data_out_Valid,
   output logic                  K285_Det,
   output logic                  Locked,
   output logic [3:0]            Align_Offset
`ifdef WORD_ALIGNER_REALIGN_CNT_EN
   ,
   output logic [7:0]            Realign_Cnt
`endif
);

   localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

   state_e                  state_q;
   logic [MW-1:0]           match_q;
   logic [LW-1:0]           miss_q;
   logic [3:0]              align_q;
   logic                    locked_q;

   logic [DATA_WIDTH-1:0]   prev_q,  prev_d;
   logic [DATA_WIDTH-1:0]   dout_q,  dout_d;
   logic                    dov_q,   dov_d;
   logic                    k285_q,  k285_d;

   logic [2*DATA_WIDTH-1:0] window;
   logic [DATA_WIDTH-1:0]   cand;
   logic                    hit;
   logic [3:0]              hit_off;
   logic                    on_offset;
   logic                    lock_evt;
   logic                    unlock_evt;

   assign window = {Data_in, prev_q};

   comma_finder u_finder (
      .window_i (window[2*DATA_WIDTH-2:0]),
      .hit_o    (hit),
      .offset_o (hit_off)
   );

   // Explicit mux keeps the select bounded to the ten legal offsets.
   always_comb begin
      cand = '0;
      for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
         if (align_q == 4'(k)) cand = window[k +: DATA_WIDTH];
      end
   end

   assign on_offset  = hit && (hit_off == align_q);
   assign lock_evt   = Data_Valid && (state_q == ST_CHECK)  && on_offset
                       && (match_q == MW'(LOCK_COUNT - 1));
   assign unlock_evt = Data_Valid && (state_q == ST_LOCKED) && hit && !on_offset
                       && (miss_q == LW'(LOSS_COUNT - 1));

   always_ff @(posedge Bit_Rate_Clk_10) begin
      if (Rst) begin
         state_q  <= ST_UNLOCKED;
         match_q  <= '0;
         miss_q   <= '0;
         align_q  <= '0;
         locked_q <= 1'b0;
      end else if (Data_Valid) begin
         unique case (state_q)
            ST_UNLOCKED: begin
               if (hit) begin
                  align_q <= hit_off;
                  if (LOCK_COUNT <= 1) begin
                     state_q  <= ST_LOCKED;
                     locked_q <= 1'b1;
                     match_q  <= '0;
                  end else begin
                     state_q <= ST_CHECK;
                     match_q <= MW'(1);
                  end
               end
            end
            ST_CHECK: begin
               if (lock_evt) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                  match_q  <= '0;
               end else if (on_offset) begin
                  match_q <= match_q + 1'b1;
               end else if (hit) begin
                  align_q <= hit_off;
                  match_q <= MW'(1);
               end
            end
            ST_LOCKED: begin
               if (unlock_evt) begin
                  state_q  <= ST_UNLOCKED;
                  locked_q <= 1'b0;
                  miss_q   <= '0;
               end else if (on_offset) begin
                  miss_q <= '0;
               end else if (hit) begin
                  miss_q <= miss_q + 1'b1;
               end
            end
            default: begin
               state_q  <= ST_UNLOCKED;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      prev_d = prev_q;
      dout_d = dout_q;
      dov_d  = 1'b0;
      k285_d = 1'b0;
      if (Data_Valid) begin
         prev_d = Data_in;
         dout_d = cand;
         dov_d  = (state_q == ST_LOCKED);
         k285_d = (state_q == ST_LOCKED) && is_k285(cand);
      end
   end

   always_ff @(posedge Bit_Rate_Clk_10) begin
      if (Rst) begin
         prev_q <= '0;
         dout_q <= '0;
         dov_q  <= 1'b0;
         k285_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         dout_q <= dout_d;
         dov_q  <= dov_d;
         k285_q <= k285_d;
      end
   end

`ifdef WORD_ALIGNER_REALIGN_CNT_EN
   logic [7:0] realign_q;

   always_ff @(posedge Bit_Rate_Clk_10) begin
      if (Rst) begin
         realign_q <= '0;
      end else if (unlock_evt && (realign_q != 8'hFF)) begin
         realign_q <= realign_q + 8'd1;
      end
   end

   assign Realign_Cnt = realign_q;
`endif

   assign Data_out       = dout_q;
   assign Data_out_Valid = dov_q;
   assign K285_Det       = k285_q;
   assign Locked         = locked_q;
   assign Align_Offset   = align_q;

endmodule

// File: tb/tb_word_aligner.sv
// Self-checking bench for word_aligner: directed table, corner sequences, random run vs. reference model.
module tb_word_aligner;

   localparam int LOCK = 3;
   localparam int LOSS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] din;
   logic       dv;
   logic [9:0] Data_out;
   logic       Data_out_Valid;
   logic       K285_Det;
   logic       Locked;
   logic [3:0] Align_Offset;
`ifdef WORD_ALIGNER_REALIGN_CNT_EN
   logic [7:0] Realign_Cnt;
`endif

   word_aligner #(.DATA_WIDTH(10), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
      .Bit_Rate_Clk_10 (clk),
      .Rst             (rst),
      .Data_in         (din),
      .Data_Valid      (dv),
      .Data_out        (Data_out),
      .Data_out_Valid  (Data_out_Valid),
      .K285_Det        (K285_Det),
      .Locked          (Locked),
      .Align_Offset    (Align_Offset)
`ifdef WORD_ALIGNER_REALIGN_CNT_EN
      ,
      .Realign_Cnt     (Realign_Cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: serial-stream view of the aligner.
   logic [9:0] m_prev, m_dout;
   bit         m_locked, m_dov, m_k;
   int         m_off, m_run, m_miss, m_realign;

   typedef struct {
      logic [9:0] din;
      bit         dv;
      bit         rst;
      bit         e_lock;
      logic [3:0] e_off;
      bit         e_dov;
      bit         e_k;
      bit         c_dout;
      logic [9:0] e_dout;
   } vec_t;

   vec_t tbl[11];

   function automatic bit is_comma(input logic [9:0] s);
      return (s == 10'h17C) || (s == 10'h283);
   endfunction

   // Word carrying the bit stream "prv then cur" with the symbol boundary k bits into the word.
   function automatic logic [9:0] mk(input logic [9:0] cur, input logic [9:0] prv, input int k);
      logic [19:0] t;
      t = {cur, prv};
      t = t >> (10 - k);
      return t[9:0];
   endfunction

   function automatic vec_t mkv(input logic [9:0] d, input bit v, input bit r, input bit l,
                                input logic [3:0] o, input bit ov, input bit kk,
                                input bit cd, input logic [9:0] ed);
      vec_t x;
      x.din = d; x.dv = v; x.rst = r; x.e_lock = l; x.e_off = o;
      x.e_dov = ov; x.e_k = kk; x.c_dout = cd; x.e_dout = ed;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [9:0] d, input bit v, input bit r);
      logic [19:0] w;
      logic [9:0]  cur;
      int          hk;
      if (r) begin
         m_prev = '0; m_dout = '0; m_dov = 0; m_k = 0;
         m_locked = 0; m_off = 0; m_run = 0; m_miss = 0; m_realign = 0;
      end else if (!v) begin
         m_dov = 0;
         m_k   = 0;
      end else begin
         w      = {d, m_prev};
         cur    = w[m_off +: 10];
         m_dout = cur;
         m_dov  = m_locked;
         m_k    = m_locked && is_comma(cur);
         hk = -1;
         for (int k = 9; k >= 0; k--) if (is_comma(w[k +: 10])) hk = k;
         if (hk >= 0) begin
            if (m_locked) begin
               if (hk == m_off) m_miss = 0;
               else begin
                  m_miss++;
                  if (m_miss == LOSS) begin
                     m_locked = 0; m_miss = 0; m_run = 0;
                     if (m_realign < 255) m_realign++;
                  end
               end
            end else if (m_run > 0 && hk == m_off) begin
               m_run++;
               if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
            end else begin
               m_off = hk;
               m_run = 1;
            end
         end
         m_prev = d;
      end
   endtask

   task automatic step(input logic [9:0] d, input bit v, input bit r);
      din = d; dv = v; rst = r;
      @(posedge clk);
      model_step(d, v, r);
      #1;
      check("data_out",  32'(Data_out),       32'(m_dout));
      check("dout_vld",  32'(Data_out_Valid), 32'(m_dov));
      check("k285_det",  32'(K285_Det),       32'(m_k));
      check("locked",    32'(Locked),         32'(m_locked));
      check("align_off", 32'(Align_Offset),   32'(m_off));
`ifdef WORD_ALIGNER_REALIGN_CNT_EN
      check("realign",   32'(Realign_Cnt),    32'(m_realign));
`endif
   endtask

   // One comma at offset k surrounded by zero symbols; optional invalid cycle after each word.
   task automatic send_comma(input int k, input logic [9:0] c, input bit gap);
      step(mk(c, 10'h000, k), 1, 0);
      if (gap) step(10'($urandom), 0, 0);
      step(mk(10'h000, c, k), 1, 0);
      if (gap) step(10'($urandom), 0, 0);
   endtask

   task automatic group(input int k, input int n);
      for (int i = 0; i < n; i++) send_comma(k, (i % 2) ? 10'h283 : 10'h17C, 0);
      step(10'h000, 1, 0);
   endtask

   initial begin
      logic [9:0] s_prev, sym;
      int         off;

      tbl[0]  = mkv(10'h17C,                 1, 1, 0, 4'd0, 0, 0, 1, 10'h000);
      tbl[1]  = mkv(mk(10'h17C, 10'h000, 3), 1, 0, 0, 4'd0, 0, 0, 1, 10'h000);
      tbl[2]  = mkv(mk(10'h000, 10'h17C, 3), 1, 0, 0, 4'd3, 0, 0, 0, 10'h000);
      tbl[3]  = mkv(mk(10'h283, 10'h000, 3), 1, 0, 0, 4'd3, 0, 0, 0, 10'h000);
      tbl[4]  = mkv(mk(10'h000, 10'h283, 3), 1, 0, 0, 4'd3, 0, 0, 0, 10'h000);
      tbl[5]  = mkv(mk(10'h17C, 10'h000, 3), 1, 0, 0, 4'd3, 0, 0, 0, 10'h000);
      tbl[6]  = mkv(mk(10'h000, 10'h17C, 3), 1, 0, 1, 4'd3, 0, 0, 1, 10'h17C);
      tbl[7]  = mkv(mk(10'h283, 10'h000, 3), 1, 0, 1, 4'd3, 1, 0, 1, 10'h000);
      tbl[8]  = mkv(mk(10'h000, 10'h283, 3), 1, 0, 1, 4'd3, 1, 1, 1, 10'h283);
      tbl[9]  = mkv(mk(10'h17C, 10'h000, 3), 1, 0, 1, 4'd3, 1, 0, 1, 10'h000);
      tbl[10] = mkv(mk(10'h000, 10'h17C, 3), 1, 0, 1, 4'd3, 1, 1, 1, 10'h17C);

      din = '0; dv = 1'b0; rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].din, tbl[i].dv, tbl[i].rst);
         check($sformatf("tbl%0d_locked", i), 32'(Locked),         32'(tbl[i].e_lock));
         check($sformatf("tbl%0d_off", i),    32'(Align_Offset),   32'(tbl[i].e_off));
         check($sformatf("tbl%0d_dov", i),    32'(Data_out_Valid), 32'(tbl[i].e_dov));
         check($sformatf("tbl%0d_k285", i),   32'(K285_Det),       32'(tbl[i].e_k));
         if (tbl[i].c_dout) check($sformatf("tbl%0d_dout", i), 32'(Data_out), 32'(tbl[i].e_dout));
      end

      // Relocation during CHECK restarts the match count at the new offset.
      step(10'h000, 1, 1);
      group(3, 2);
      group(7, 1);
      check("realign_check_locked", 32'(Locked), 32'd0);
      check("realign_check_off",    32'(Align_Offset), 32'd7);
      group(7, 1);
      check("new_off_2nd_locked", 32'(Locked), 32'd0);
      group(7, 1);
      check("new_off_3rd_locked", 32'(Locked), 32'd1);
      check("new_off_3rd_off",    32'(Align_Offset), 32'd7);

      // Loss of lock needs LOSS consecutive wrong-offset commas.
      step(10'h000, 1, 1);
      group(3, 3);
      check("loss_pre_locked", 32'(Locked), 32'd1);
      group(5, 3);
      check("loss_3_locked", 32'(Locked), 32'd1);
      check("loss_3_off",    32'(Align_Offset), 32'd3);
      group(3, 1);
      group(5, 3);
      check("loss_rearm_locked", 32'(Locked), 32'd1);
      group(5, 1);
      check("loss_4_locked", 32'(Locked), 32'd0);
      check("loss_4_off",    32'(Align_Offset), 32'd3);

      // Gapped valid: lock after the same three valid commas.
      step(10'h000, 1, 1);
      send_comma(3, 10'h17C, 1);
      send_comma(3, 10'h283, 1);
      check("gap_2_locked", 32'(Locked), 32'd0);
      send_comma(3, 10'h17C, 1);
      check("gap_3_locked", 32'(Locked), 32'd1);
      send_comma(3, 10'h283, 0);
      check("gap_k285", 32'(K285_Det), 32'd1);
      step(10'h17C, 0, 0);
      check("gap_invalid_dov", 32'(Data_out_Valid), 32'd0);
      check("gap_invalid_k",   32'(K285_Det), 32'd0);

      // Reset while locked, with Data_Valid high.
      step(mk(10'h17C, 10'h000, 3), 1, 1);
      check("rst_locked", 32'(Locked), 32'd0);
      check("rst_off",    32'(Align_Offset), 32'd0);
      check("rst_dout",   32'(Data_out), 32'd0);
      check("rst_dov",    32'(Data_out_Valid), 32'd0);
      check("rst_k",      32'(K285_Det), 32'd0);
      group(3, 2);
      check("relock_2_locked", 32'(Locked), 32'd0);
      group(3, 1);
      check("relock_3_locked", 32'(Locked), 32'd1);

`ifdef WORD_ALIGNER_REALIGN_CNT_EN
      step(10'h000, 1, 1);
      for (int r = 0; r < 2; r++) begin
         group(3, 3);
         group(6, 4);
      end
      check("realign_cnt_2", 32'(Realign_Cnt), 32'd2);
`endif

      // Random symbol stream with occasional phase jumps, invalid cycles and resets.
      step(10'h000, 1, 1);
      s_prev = '0;
      off    = 3;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            step(10'($urandom), 1, 1);
            s_prev = '0;
         end else if ($urandom_range(0, 4) == 0) begin
            step(10'($urandom), 0, 0);
         end else begin
            if ($urandom_range(0, 149) == 0) off = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) sym = ($urandom_range(0, 1) != 0) ? 10'h17C : 10'h283;
            else                           sym = 10'($urandom);
            step(mk(sym, s_prev, off), 1, 0);
            s_prev = sym;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/word_aligner.md
WORD_ALIGNER -- requirements
Module: word_aligner
Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 10, symbol width (fixed 10); LOCK_COUNT, 3, consecutive same-offset commas to lock; LOSS_COUNT, 4, consecutive wrong-offset commas to unlock.
REQ-002 Bit_Rate_Clk_10  input  1  word clock, rising edge; design has exactly one clock.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 Data_in  input  10  unaligned word from PMA receive deserializer; bit 0 = earliest received bit.
REQ-005 Data_Valid  input  1  Data_in qualifier.
REQ-006 Data_out  output  10  aligned 10b symbol, bit 0 = bit 'a'.
REQ-007 Data_out_Valid  output  1  Data_out qualifier.
REQ-008 K285_Det  output  1  Data_out is K28.5 (either disparity).
REQ-009 Locked  output  1  alignment acquired.
REQ-010 Align_Offset  output  4  current/candidate bit offset, 0..9.
Function
REQ-011 Window W[19:0] = {Data_in, prev}; prev = last valid Data_in; candidate at offset k = W[k+9:k], k=0..9.
REQ-012 Comma = candidate equal to 10'h17C (RD-) or 10'h283 (RD+); multiple hits in one window -> lowest k wins.
REQ-013 Data_Valid low: no state, counter, prev or output-data update; Data_out_Valid=0, K285_Det=0.
REQ-014 FSM states UNLOCKED, CHECK, LOCKED; all transitions only on valid words.
REQ-015 UNLOCKED: comma at k -> Align_Offset=k, match count=1, go CHECK; else stay.
REQ-016 CHECK: comma at Align_Offset -> count+1, reaching LOCK_COUNT -> LOCKED; comma at other offset -> Align_Offset=new k, count=1, stay CHECK; non-comma -> no change.
REQ-017 LOCKED: comma at Align_Offset clears miss count; comma at other offset -> miss+1, reaching LOSS_COUNT -> UNLOCKED with miss=0; non-comma -> no change; Align_Offset frozen.
REQ-018 Locked=1 exactly while state is LOCKED, registered (asserts cycle after locking comma).
REQ-019 Data_out = W[Align_Offset+9:Align_Offset], registered, latency 1 cycle from Data_Valid; Data_out_Valid = delayed Data_Valid AND state LOCKED at that edge.
REQ-020 K285_Det registered with Data_out, high only when Data_out_Valid=1 and Data_out is a comma.
REQ-021 Counters saturate; no wrap-around beyond LOCK_COUNT/LOSS_COUNT.
Reset
REQ-022 Rst high at clock edge: state UNLOCKED, prev=0, counts=0, Data_out=0, Data_out_Valid=0, K285_Det=0, Locked=0, Align_Offset=0.
REQ-023 Rst asserted mid-lock clears lock at next edge; Rst overrides Data_Valid.
Configuration
REQ-024 Macro WORD_ALIGNER_REALIGN_CNT_EN defined: extra output Realign_Cnt [7:0], +1 per LOCKED->UNLOCKED transition, saturating at 8'hFF, reset 0.
REQ-025 Macro undefined: port and counter absent; all other behaviour identical.
Structure
REQ-026 Package word_aligner_pkg holds K28.5 constants 10'h17C/10'h283 and FSM state typedef.
REQ-027 One sub-module comma_finder: combinational search of W over 10 offsets, outputs hit and lowest offset.
Verification
REQ-028 Stream K28.5 (10'h17C/10'h283 alternating) shifted by 3 bits with D-symbols between -> Locked=1 after 3rd comma, Align_Offset=3, Data_out shows 10'h17C with K285_Det=1.
REQ-029 Two commas at offset 3 then one at offset 7 -> stays CHECK, Align_Offset=7, count=1; no Locked.
REQ-030 Locked at offset 3, 4 consecutive commas at offset 5 -> Locked falls after 4th; 3 then 1 at offset 3 -> stays locked.
REQ-031 Data_Valid toggling 1/0 during lock sequence -> lock after same 3 valid commas; Data_out_Valid=0 on invalid cycles.
REQ-032 Rst pulsed while locked -> next cycle all outputs 0, relock requires 3 new commas.
REQ-033 With WORD_ALIGNER_REALIGN_CNT_EN, 2 lock/unlock cycles -> Realign_Cnt=2.
